// File: rtl/led_blink_sequencer.sv
// Purpose : sequenced LED blinker; N blinks of programmable on/off length, optional gap and repeat.
// Latency : outputs registered; an accepted start lights the LED on the next cycle.
// Backpr. : start is a one-cycle command taken only in IDLE; while busy, start is ignored and stop aborts.
//
// Ports:
//   sys_clk, sys_rst_n  - clock and synchronous active-low reset
//   start, stop         - command pulses (start honoured in IDLE, stop honoured when busy)
//   blink_num, on_ticks, off_ticks, gap_ticks, repeat_en - sequence config, latched on accepted start
//   busy, done, led_out - status and LED drive (all registered)
//   done_cnt            - completed-pass counter, present only when DONE_CNT_EN is defined
//
// Optional feature macro: DONE_CNT_EN

module led_blink_sequencer #(
    parameter int unsigned      CNT_W   = 25,
    parameter logic [CNT_W-1:0] CNT_MAX = CNT_W'(24_999_999),
    parameter int unsigned      NUM_W   = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [NUM_W-1:0] blink_num,
    input  logic [NUM_W-1:0] on_ticks,
    input  logic [NUM_W-1:0] off_ticks,
    input  logic [NUM_W-1:0] gap_ticks,
    input  logic             repeat_en,
    output logic             busy,
    output logic             done,
    output logic             led_out
`ifdef DONE_CNT_EN
    ,
    output logic [7:0]       done_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] prescaler;
    logic [NUM_W-1:0] tick_cnt;
    logic [NUM_W-1:0] blink_cnt;

    // Configuration captured on an accepted start; stable for the whole sequence.
    logic [NUM_W-1:0] cfg_num;
    logic [NUM_W-1:0] cfg_on;
    logic [NUM_W-1:0] cfg_off;
    logic [NUM_W-1:0] cfg_gap;
    logic             cfg_rep;

    logic             tick;
    logic [NUM_W-1:0] cur_len;
    logic [NUM_W-1:0] len_eff;
    logic             state_exit;
    logic [NUM_W:0]   blink_next;
    logic             start_ok;
    logic             pass_end;
    logic             done_nxt;
    logic             led_nxt;
    logic             busy_nxt;
    logic             state_entry;

    // ------------------------------------------------------------------
    // Timing helpers
    // ------------------------------------------------------------------
    assign tick = (prescaler == CNT_MAX);

    always_comb begin
        cur_len = NUM_W'(1);
        case (state)
            S_ON:    cur_len = cfg_on;
            S_OFF:   cur_len = cfg_off;
            S_GAP:   cur_len = cfg_gap;
            default: cur_len = NUM_W'(1);
        endcase
    end

    // A programmed length of zero behaves as one tick so the state is never skipped.
    assign len_eff    = (cur_len == '0) ? NUM_W'(1) : cur_len;
    assign state_exit = tick && (tick_cnt == (len_eff - NUM_W'(1)));

    // One extra bit so the comparison against cfg_num cannot wrap.
    assign blink_next = {1'b0, blink_cnt} + (NUM_W + 1)'(1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        pass_end  = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                // start beats a simultaneous stop here because stop has no meaning in IDLE.
                if (start) begin
                    if (blink_num != '0) begin
                        state_nxt = S_ON;
                        start_ok  = 1'b1;
                    end else begin
                        done_nxt  = 1'b1;
                    end
                end
            end
            S_ON: begin
                if (state_exit) begin
                    state_nxt = S_OFF;
                end
            end
            S_OFF: begin
                if (state_exit) begin
                    if (blink_next < {1'b0, cfg_num}) begin
                        state_nxt = S_ON;
                    end else begin
                        pass_end = 1'b1;
                        if (cfg_rep) begin
                            state_nxt = S_GAP;
                        end else begin
                            state_nxt = S_IDLE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (state_exit) begin
                    state_nxt = S_ON;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a pass finishing on this same tick.
        if ((state != S_IDLE) && stop) begin
            state_nxt = S_IDLE;
            pass_end  = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output logic (values registered below, derived from the next state)
    // ------------------------------------------------------------------
    always_comb begin
        led_nxt  = (state_nxt == S_ON);
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            led_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            led_out <= led_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and per-state tick counter
    // ------------------------------------------------------------------
    // Entering a state restarts its timing so every state lasts a whole number of ticks.
    assign state_entry = (state_nxt != state);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            prescaler <= '0;
            tick_cnt  <= '0;
        end else if ((state_nxt == S_IDLE) || state_entry) begin
            prescaler <= '0;
            tick_cnt  <= '0;
        end else if (tick) begin
            prescaler <= '0;
            tick_cnt  <= tick_cnt + NUM_W'(1);
        end else begin
            prescaler <= prescaler + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Blink counter and configuration latch
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            blink_cnt <= '0;
        end else if ((state_nxt == S_IDLE) || start_ok) begin
            blink_cnt <= '0;
        end else if ((state == S_OFF) && state_exit) begin
            blink_cnt <= pass_end ? '0 : blink_next[NUM_W-1:0];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cfg_num <= '0;
            cfg_on  <= '0;
            cfg_off <= '0;
            cfg_gap <= '0;
            cfg_rep <= 1'b0;
        end else if (start_ok) begin
            cfg_num <= blink_num;
            cfg_on  <= on_ticks;
            cfg_off <= off_ticks;
            cfg_gap <= gap_ticks;
            cfg_rep <= repeat_en;
        end
    end

`ifdef DONE_CNT_EN
    // ------------------------------------------------------------------
    // Completed-pass counter: counts repeat passes too, saturates at 255.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            done_cnt <= 8'd0;
        end else if (pass_end && (done_cnt != 8'hFF)) begin
            done_cnt <= done_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Bench for led_blink_sequencer with a 5-cycle tick (CNT_MAX=4).
// Reference: expected outputs are derived from cycle offset since the accepted start
// using the sequence arithmetic (blink period, pass length, gap), not from RTL state.

module tb_led_blink_sequencer;

    localparam int P = 5;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       start;
    logic       stop;
    logic [3:0] blink_num;
    logic [3:0] on_ticks;
    logic [3:0] off_ticks;
    logic [3:0] gap_ticks;
    logic       repeat_en;
    logic       busy;
    logic       done;
    logic       led_out;
`ifdef DONE_CNT_EN
    logic [7:0] done_cnt;
`endif

    always #5 sys_clk = ~sys_clk;

    led_blink_sequencer #(
        .CNT_W   (3),
        .CNT_MAX (3'd4),
        .NUM_W   (4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .stop      (stop),
        .blink_num (blink_num),
        .on_ticks  (on_ticks),
        .off_ticks (off_ticks),
        .gap_ticks (gap_ticks),
        .repeat_en (repeat_en),
        .busy      (busy),
        .done      (done),
        .led_out   (led_out)
`ifdef DONE_CNT_EN
        ,
        .done_cnt  (done_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_act  = 0;   // a sequence was accepted and not aborted/reset
    int mk     = 0;   // cycles since the accepted start (1 = first cycle after)
    int c_bn   = 0;
    int c_on   = 0;
    int c_off  = 0;
    int c_gap  = 0;
    int c_rep  = 0;
    int m_dcnt = 0;

    function automatic int eff(input int v);
        return ((v == 0) ? 1 : v) * P;
    endfunction

    // {led_out, busy, done} expected in cycle mk
    function automatic logic [2:0] expect_out();
        int  bl;
        int  pl;
        int  t;
        logic led;
        if (m_act == 0) return 3'b000;
        if (c_bn == 0) return (mk == 1) ? 3'b001 : 3'b000;
        bl = eff(c_on) + eff(c_off);
        pl = c_bn * bl;
        if (c_rep == 0) begin
            if (mk <= pl) begin
                t   = mk - 1;
                led = ((t % bl) < eff(c_on));
                return {led, 1'b1, 1'b0};
            end
            if (mk == pl + 1) return 3'b001;
            return 3'b000;
        end
        t   = (mk - 1) % (pl + eff(c_gap));
        led = (t < pl) && ((t % bl) < eff(c_on));
        return {led, 1'b1, 1'b0};
    endfunction

    // True when cycle mk is the last cycle of a complete pass
    function automatic bit pass_last();
        int pl;
        if ((m_act == 0) || (c_bn == 0)) return 1'b0;
        pl = c_bn * (eff(c_on) + eff(c_off));
        if (c_rep == 0) return (mk == pl);
        return (((mk - 1) % (pl + eff(c_gap))) == (pl - 1));
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model with what the DUT samples, then check
    // the outputs away from the edge. start/stop are cleared afterwards (pulses).
    task automatic step(input string tag);
        logic [2:0] e;
        @(posedge sys_clk);
        e = expect_out();
        if (!sys_rst_n) begin
            m_act  = 0;
            m_dcnt = 0;
        end else if (e[1] && stop) begin
            m_act = 0;
        end else if (!e[1] && start) begin
            m_act = 1;
            mk    = 1;
            c_bn  = int'(blink_num);
            c_on  = int'(on_ticks);
            c_off = int'(off_ticks);
            c_gap = int'(gap_ticks);
            c_rep = int'(repeat_en);
        end else begin
            if (pass_last() && (m_dcnt < 255)) m_dcnt++;
            if (m_act != 0) mk++;
        end
        @(negedge sys_clk);
        e = expect_out();
        check({tag, " led_out"}, {7'd0, led_out}, {7'd0, e[2]});
        check({tag, " busy"},    {7'd0, busy},    {7'd0, e[1]});
        check({tag, " done"},    {7'd0, done},    {7'd0, e[0]});
`ifdef DONE_CNT_EN
        check({tag, " done_cnt"}, done_cnt, 8'(m_dcnt));
`endif
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic set_cfg(input int bn, input int on, input int off, input int gap, input int rep);
        blink_num = 4'(bn);
        on_ticks  = 4'(on);
        off_ticks = 4'(off);
        gap_ticks = 4'(gap);
        repeat_en = 1'(rep);
    endtask

    int done_seen;
    int len;

    initial begin
        sys_rst_n = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        set_cfg(0, 0, 0, 0, 0);

        // Reset state
        step("reset");
        step("reset");
        sys_rst_n = 1'b1;
        step("idle");

        // Two blinks, on=1 off=2, no repeat; done exactly once with busy low
        set_cfg(2, 1, 2, 0, 0);
        start = 1'b1;
        step("seq1");
        done_seen = 0;
        for (int k = 2; k <= 36; k++) begin
            step("seq1");
            if (done === 1'b1) done_seen++;
        end
        check("seq1 done count", 8'(done_seen), 8'd1);

        // Second start at cycle 8 with other config must be ignored
        set_cfg(2, 1, 2, 0, 0);
        start = 1'b1;
        step("ignore");
        for (int k = 2; k <= 36; k++) begin
            if (k == 9) begin
                start = 1'b1;
                set_cfg(5, 3, 3, 3, 1);
            end
            step("ignore");
        end

        // blink_num == 0: single done pulse, nothing else
        set_cfg(0, 1, 1, 1, 0);
        start = 1'b1;
        step("zero");
        for (int k = 2; k <= 4; k++) step("zero");

        // stop in IDLE has no effect; start+stop together in IDLE starts
        stop = 1'b1;
        step("idle_stop");
        set_cfg(2, 1, 2, 0, 0);
        start = 1'b1;
        stop  = 1'b1;
        step("start_stop");
        for (int k = 2; k <= 12; k++) begin
            if (k == 12) stop = 1'b1;
            step("start_stop");
        end
        step("start_stop");

        // Repeat with zero on/off, gap 3; abort mid-gap of the second pass
        set_cfg(1, 0, 0, 3, 1);
        start = 1'b1;
        step("repeat");
        for (int k = 2; k <= 50; k++) begin
            if (k == 44) stop = 1'b1;
            step("repeat");
        end

        // Reset for one cycle at cycle 12, then a clean first-scenario run
        set_cfg(2, 1, 2, 0, 0);
        start = 1'b1;
        step("rst_mid");
        for (int k = 2; k <= 16; k++) begin
            if (k == 13) sys_rst_n = 1'b0;
            step("rst_mid");
            sys_rst_n = 1'b1;
        end
        start = 1'b1;
        step("after_rst");
        for (int k = 2; k <= 33; k++) step("after_rst");

        // Randomized configs, stray starts and occasional aborts
        for (int n = 0; n < 14; n++) begin
            set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 1)));
            start = 1'b1;
            step("rand");
            len = int'($urandom_range(20, 90));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 9) == 0) begin
                    start = 1'b1;
                    set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                            int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                            int'($urandom_range(0, 1)));
                end
                if ($urandom_range(0, 39) == 0) stop = 1'b1;
                step("rand");
            end
            stop = 1'b1;
            step("rand_end");
            step("rand_end");
        end

`ifdef DONE_CNT_EN
        // Pass counter: one pass every 15 cycles, run long enough to saturate
        sys_rst_n = 1'b0;
        step("dcnt_rst");
        sys_rst_n = 1'b1;
        set_cfg(1, 1, 1, 1, 1);
        start = 1'b1;
        step("dcnt");
        for (int k = 2; k <= 15 * 260; k++) step("dcnt");
        check("dcnt saturated", done_cnt, 8'hFF);
        stop = 1'b1;
        step("dcnt_abort");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
